fifo_nibble_packer: RTL

- Downstream consumer stage for the 4-bit shift-register FIFO.
- Drains the FIFO one word at a time via its rd/empty/rdata interface and packs LANES consecutive words into one wide output word.
- Presents each packed word on a valid/ready handshake to the next stage.
- A flush input forces out a partially filled word.

---
 rtl/fifo_nibble_packer_if.sv | 28 ++
 rtl/fifo_nibble_packer.sv | 93 +++++++++
 2 files changed

// File: rtl/fifo_nibble_packer_if.sv
// Bundles the FIFO read side, the flush request and the packed-word handshake.
// master = the packer, slave = its surroundings (FIFO, writer monitor, consumer).
interface fifo_nibble_packer_if #(
    parameter int WIDTH = 4,
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES + 1)
);
    logic                   empty;
    logic                   fifo_wr;
    logic [WIDTH-1:0]       rdata;
    logic                   rd;
    logic                   flush;
    logic [WIDTH*LANES-1:0] out_data;
    logic [CW-1:0]          out_count;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport master (
        input  empty, fifo_wr, rdata, flush, out_ready,
        output rd, out_data, out_count, out_valid, busy
    );

    modport slave (
        output empty, fifo_wr, rdata, flush, out_ready,
        input  rd, out_data, out_count, out_valid, busy
    );
endinterface

// File: rtl/fifo_nibble_packer.sv
// Drains a narrow FIFO one word at a time and packs LANES words into one wide
// word on a valid/ready handshake; flush emits a partially filled word.
//
//  state | meaning
//  FETCH | read the FIFO when it has data and no write is in progress
//  WAIT  | read in flight; rdata lands in lane[count]
//  OUT   | packed word held on out_data/out_count until out_ready
module fifo_nibble_packer #(
    parameter int WIDTH = 4,
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES + 1)
) (
    input logic                  clk,
    input logic                  rst,
    fifo_nibble_packer_if.master bus
);
    typedef enum logic [1:0] {FETCH, WAIT, OUT} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [WIDTH*LANES-1:0] r_buf;
    logic                   r_flush_pend;
    logic                   r_out_valid;

    logic                   w_rd;
    logic                   w_flush_req;
    logic [CW-1:0]          w_count_inc;
    logic                   w_last_lane;

    // Gated by reset so a non-empty FIFO is never read while held in reset.
    assign w_rd        = rst && (r_state == FETCH) && !bus.empty && !bus.fifo_wr;
    assign w_flush_req = bus.flush || r_flush_pend;
    assign w_count_inc = r_count + 1'b1;
    assign w_last_lane = (w_count_inc == CW'(LANES));

    assign bus.rd        = w_rd;
    assign bus.out_data  = r_buf;
    assign bus.out_count = r_count;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state != FETCH) || (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FETCH;
            r_count      <= '0;
            r_buf        <= '0;
            r_flush_pend <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_rd) begin
                        r_state <= WAIT;
                    end else if (w_flush_req) begin
                        if (r_count != '0) begin
                            r_state     <= OUT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_flush_pend <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (r_count == CW'(i)) begin
                            r_buf[i*WIDTH +: WIDTH] <= bus.rdata;
                        end
                    end
                    r_count <= w_count_inc;
                    if (bus.flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_last_lane || w_flush_req) begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_buf        <= '0;
                        r_count      <= '0;
                        r_flush_pend <= 1'b0;
                        r_out_valid  <= 1'b0;
                        r_state      <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end
endmodule
